sample_loader: RTL and testbench

//  Writer side of the NN input buffer: accepts one input sample as a byte stream (valid/ready),

---
 rtl/sample_loader_pkg.sv | 23 ++
 rtl/sample_loader_word_packer.sv | 57 +++++
 rtl/sample_loader.sv | 109 ++++++++++
 tb/tb_sample_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_loader_pkg.sv
// ---------------------------------------------------------------
// sample_loader_pkg : shared sizes and FSM encodings for the loader
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package sample_loader_pkg;

  localparam int SIZE  = 8;
  localparam int ELEMS = 8;
  localparam int DEPTH = 8;
  localparam int WORD  = SIZE * ELEMS;
  localparam int AW    = $clog2(DEPTH);
  localparam int EW    = $clog2(ELEMS);
  localparam int WCW   = AW + 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sample_loader_word_packer.sv
// ---------------------------------------------------------------
// sample_loader_word_packer : packs stream elements into one word
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sample_loader_word_packer
  import sample_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [SIZE-1:0] data_i,
  input  logic            last_i,
  output logic [WORD-1:0] word_o,
  output logic            word_full_o,
  output logic            done_o
);

  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [WORD-1:0] pack_q, pack_d;

  // Slots above ecnt are always zero, so an early-closed word is zero-padded for free.
  always_comb begin
    word_o = pack_q;
    word_o[ecnt_q*SIZE +: SIZE] = data_i;
  end

  assign word_full_o = (ecnt_q == EW'(ELEMS - 1));
  assign done_o      = push_i && (word_full_o || last_i);

  always_comb begin
    pack_d = pack_q;
    ecnt_d = ecnt_q;
    if (clear_i || done_o) begin
      pack_d = '0;
      ecnt_d = '0;
    end else if (push_i) begin
      pack_d = word_o;
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pack_q <= '0;
      ecnt_q <= '0;
    end else begin
      pack_q <= pack_d;
      ecnt_q <= ecnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_loader.sv
// ---------------------------------------------------------------
// sample_loader : NN input buffer writer; loads, pads and holds one sample
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sample_loader
  import sample_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [SIZE-1:0] in_data_i,
  input  logic            in_last_i,
  input  logic [AW-1:0]   rdaddr_i,
  output logic [WORD-1:0] rddata_o,
  output logic            full_o,
  input  logic            release_i,
  output logic            err_o
);

  logic [1:0]      state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic [WORD-1:0] buf_q [DEPTH];

  logic            w_xfer;
  logic            w_clear;
  logic [WORD-1:0] w_word;
  logic            w_word_full;
  logic            w_done;
  logic            w_last_word;
  logic            w_wr_en;
  logic [WORD-1:0] w_wr_data;

  assign in_ready_o  = (state_q == ST_LOAD);
  assign full_o      = (state_q == ST_FULL);
  assign err_o       = err_q;
  assign rddata_o    = buf_q[rdaddr_i];
  assign w_xfer      = in_valid_i && in_ready_o;
  assign w_clear     = full_o && release_i;
  assign w_last_word = (wcnt_q == WCW'(DEPTH - 1));

  sample_loader_word_packer u_packer (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (w_clear),
    .push_i      (w_xfer),
    .data_i      (in_data_i),
    .last_i      (in_last_i),
    .word_o      (w_word),
    .word_full_o (w_word_full),
    .done_o      (w_done)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    case (state_q)
      ST_LOAD: begin
        if (w_done) begin
          w_wr_en   = 1'b1;
          w_wr_data = w_word;
          wcnt_d    = wcnt_q + 1'b1;
          // A clean frame ends exactly on the final element of the final word.
          if (in_last_i != (w_last_word && w_word_full)) err_d = 1'b1;
          if (w_last_word)    state_d = ST_FULL;
          else if (in_last_i) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        w_wr_en = 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        if (w_last_word) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (release_i) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      if (w_wr_en) buf_q[wcnt_q[AW-1:0]] <= w_wr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sample_loader.sv
// ---------------------------------------------------------------
// tb_sample_loader : directed scoreboard bench for sample_loader
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_sample_loader;
  import sample_loader_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [SIZE-1:0] in_data_i;
  logic            in_last_i;
  logic [AW-1:0]   rdaddr_i;
  logic [WORD-1:0] rddata_o;
  logic            full_o;
  logic            release_i;
  logic            err_o;

  always #5 clk = ~clk;

  sample_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .rdaddr_i   (rdaddr_i),
    .rddata_o   (rddata_o),
    .full_o     (full_o),
    .release_i  (release_i),
    .err_o      (err_o)
  );

  typedef struct {
    logic [DEPTH-1:0][WORD-1:0] w;
    logic                       err;
    logic                       full;
  } exp_t;

  exp_t        sb[$];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          req_cnt = 0;
  int          chk_done = 0;
  int          nchk    = 0;
  logic [7:0]  dat [64];

  task automatic cmp(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks a held sample whenever full rises or the stimulus requests a readback.
  initial begin : monitor
    logic full_prev;
    int   req_seen;
    exp_t e;
    full_prev = 1'b0;
    req_seen  = 0;
    rdaddr_i  = '0;
    forever begin
      @(negedge clk);
      if ((full_o && !full_prev) || (req_cnt != req_seen)) begin
        if (req_cnt != req_seen) req_seen++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: full=%0b with empty scoreboard", full_o);
        end else begin
          e = sb.pop_front();
          cmp("full", {63'd0, full_o}, {63'd0, e.full});
          cmp("err",  {63'd0, err_o},  {63'd0, e.err});
          for (int a = 0; a < DEPTH; a++) begin
            rdaddr_i = AW'(a);
            #1;
            cmp($sformatf("rddata[%0d]", a), rddata_o, e.w[a]);
          end
        end
        chk_done++;
      end
      full_prev = full_o;
    end
  end

  task automatic push_model(input int n, input logic err, input logic full);
    exp_t e;
    e.err  = err;
    e.full = full;
    for (int w = 0; w < DEPTH; w++)
      for (int j = 0; j < ELEMS; j++)
        e.w[w][j*SIZE +: SIZE] = ((w*ELEMS + j) < n) ? dat[w*ELEMS + j] : 8'h00;
    sb.push_back(e);
  endtask

  task automatic push_const(input logic [WORD-1:0] w0, input logic [WORD-1:0] w1,
                            input logic [WORD-1:0] rest, input logic err, input logic full);
    exp_t e;
    e.err  = err;
    e.full = full;
    for (int w = 0; w < DEPTH; w++) e.w[w] = rest;
    e.w[0] = w0;
    e.w[1] = w1;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int   n;
    logic taken;
    n = 0;
    taken = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    while (!taken && n < 20) begin
      @(negedge clk);
      taken = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (!taken) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: element %h not accepted", d);
    end
  endtask

  task automatic load(input int n, input logic with_last, input logic gap);
    for (int i = 0; i < n; i++) begin
      send(dat[i], with_last && (i == n - 1));
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_checks(input int tgt);
    int t;
    t = 0;
    while (chk_done < tgt && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (chk_done < tgt) begin
      n_vec++;
      n_err++;
      $display("FAIL check_timeout: got %0d readbacks expected %0d", chk_done, tgt);
    end
  endtask

  task automatic pulse_release();
    release_i = 1'b1;
    @(posedge clk);
    #1;
    release_i = 1'b0;
  endtask

  initial begin : stimulus
    rstn       = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    release_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state: ready, empty, no error, buffer cleared.
    cmp("ready_after_reset", {63'd0, in_ready_o}, 64'd1);
    push_const('0, '0, '0, 1'b0, 1'b0);
    req_cnt++; nchk++;
    wait_checks(nchk);

    // 1: ascending 0x01..0x40 with clean framing.
    for (int i = 0; i < 64; i++) dat[i] = 8'(i + 1);
    push_const(64'h0807060504030201, 64'h100F0E0D0C0B0A09, '0, 1'b0, 1'b1);
    sb[sb.size()-1].w[7] = 64'h403F3E3D3C3B3A39;
    for (int w = 2; w < 7; w++)
      for (int j = 0; j < ELEMS; j++) sb[sb.size()-1].w[w][j*8 +: 8] = 8'(w*8 + j + 1);
    load(64, 1'b1, 1'b0);
    nchk++;
    wait_checks(nchk);
    pulse_release();
    cmp("full_after_release", {63'd0, full_o}, 64'd0);
    cmp("ready_after_release", {63'd0, in_ready_o}, 64'd1);

    // 2: gapped valid, then extra elements while held.
    for (int i = 0; i < 64; i++) dat[i] = 8'(i*3 + 7);
    push_model(64, 1'b0, 1'b1);
    load(64, 1'b1, 1'b1);
    nchk++;
    wait_checks(nchk);
    in_valid_i = 1'b1;
    in_data_i  = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      cmp("ready_in_full", {63'd0, in_ready_o}, 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    push_model(64, 1'b0, 1'b1);
    req_cnt++; nchk++;
    wait_checks(nchk);
    pulse_release();

    // 3: early last on element 10 -> zero-padded remainder.
    for (int i = 0; i < 64; i++) dat[i] = 8'hFF;
    push_const(64'hFFFFFFFFFFFFFFFF, 64'h000000000000FFFF, '0, 1'b1, 1'b1);
    load(10, 1'b1, 1'b0);
    cmp("ready_in_pad", {63'd0, in_ready_o}, 64'd0);
    cmp("full_in_pad",  {63'd0, full_o},     64'd0);
    nchk++;
    wait_checks(nchk);
    pulse_release();

    // 4: missing last -> error, sticky across release.
    for (int i = 0; i < 64; i++) dat[i] = 8'(i) ^ 8'h3C;
    push_model(64, 1'b1, 1'b1);
    load(64, 1'b0, 1'b0);
    nchk++;
    wait_checks(nchk);
    pulse_release();
    cmp("ready_after_err_release", {63'd0, in_ready_o}, 64'd1);
    cmp("full_after_err_release",  {63'd0, full_o},     64'd0);
    cmp("err_sticky",              {63'd0, err_o},      64'd1);

    // 5: constant 0x80 sample.
    for (int i = 0; i < 64; i++) dat[i] = 8'h80;
    push_const(64'h8080808080808080, 64'h8080808080808080, 64'h8080808080808080, 1'b1, 1'b1);
    load(64, 1'b1, 1'b0);
    nchk++;
    wait_checks(nchk);
    pulse_release();

    // 6: reset mid-sample, then a fresh clean sample.
    for (int i = 0; i < 64; i++) dat[i] = 8'(8'hC0 - i);
    load(30, 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_const('0, '0, '0, 1'b0, 1'b0);
    req_cnt++; nchk++;
    wait_checks(nchk);
    cmp("ready_after_midreset", {63'd0, in_ready_o}, 64'd1);
    push_model(64, 1'b0, 1'b1);
    load(64, 1'b1, 1'b0);
    nchk++;
    wait_checks(nchk);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
